// File: rtl/multdiv_param.sv
// multdiv_param: iterative MIPS multiply/divide unit owning HI/LO, with madd/msub accumulate,
// cancel and a done pulse; operand width and bits retired per clock are parameters.
module multdiv_param #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             signedop,
  input  logic             cancel,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] prodh,
  output logic [WIDTH-1:0] prodl,
  output logic             run,
  output logic             done,
  output logic             dividebyzero
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MADD = 2'b10;
  localparam logic [1:0] OP_MSUB = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ITER  = 2'b01,
    ST_FIXUP = 2'b10
  } state_t;

  // One clock of BITS_PER_CYCLE shift-add (mult) or restoring-subtract (div) steps on HI:LO.
  function automatic logic [2*WIDTH-1:0] iter_step(input logic             is_div,
                                                   input logic [WIDTH-1:0] hi_in,
                                                   input logic [WIDTH-1:0] lo_in,
                                                   input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH:0]   t;
    hi = hi_in;
    lo = lo_in;
    t  = {(WIDTH+1){1'b0}};
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div) begin
        t  = {hi, lo[WIDTH-1]};
        lo = {lo[WIDTH-2:0], 1'b0};
        if (t >= {1'b0, d}) begin
          t     = t - {1'b0, d};
          lo[0] = 1'b1;
        end else begin
          lo[0] = 1'b0;
        end
        hi = t[WIDTH-1:0];
      end else begin
        t  = {1'b0, hi} + (lo[0] ? {1'b0, d} : {(WIDTH+1){1'b0}});
        lo = {t[0], lo[WIDTH-1:1]};
        hi = t[WIDTH:1];
      end
    end
    return {hi, lo};
  endfunction

  state_t            state_r, state_s;
  logic [1:0]        op_r, op_s;
  logic              xs_r, xs_s;
  logic              ys_r, ys_s;
  logic              dbz_pend_r, dbz_pend_s;
  logic [WIDTH-1:0]  opnd_r, opnd_s;
  logic [WIDTH-1:0]  work_hi_r, work_hi_s;
  logic [WIDTH-1:0]  work_lo_r, work_lo_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [WIDTH-1:0]  prodh_r, prodh_s;
  logic [WIDTH-1:0]  prodl_r, prodl_s;
  logic              run_r, run_s;
  logic              done_r, done_s;
  logic              dbz_r, dbz_s;
  logic              dbz_prev_r, dbz_prev_s;

  logic              x_neg_s, y_neg_s;
  logic [WIDTH-1:0]  step_hi_s, step_lo_s;
  logic [2*WIDTH-1:0] prod_mag_s, prod_s, result_s;
  logic [WIDTH-1:0]  quot_s, rem_s;

  assign x_neg_s = signedop & x[WIDTH-1];
  assign y_neg_s = signedop & y[WIDTH-1];
  assign {step_hi_s, step_lo_s} = iter_step(op_r == OP_DIV, work_hi_r, work_lo_r, opnd_r);

  // Sign correction, divide-by-zero result and HI:LO accumulate applied in FIXUP
  always_comb begin
    prod_mag_s = {work_hi_r, work_lo_r};
    prod_s     = (xs_r ^ ys_r) ? -prod_mag_s : prod_mag_s;
    quot_s     = (xs_r ^ ys_r) ? -work_lo_r : work_lo_r;
    rem_s      = xs_r ? -work_hi_r : work_hi_r;
    case (op_r)
      OP_MULT: result_s = prod_s;
      OP_DIV:  result_s = {rem_s, quot_s};
      OP_MADD: result_s = {prodh_r, prodl_r} + prod_s;
      OP_MSUB: result_s = {prodh_r, prodl_r} - prod_s;
      default: result_s = prod_s;
    endcase
    if (dbz_pend_r) begin
      result_s = {work_hi_r, {WIDTH{1'b1}}};
    end else begin
      result_s = result_s;
    end
  end

  // Next-state and working-register update for IDLE -> ITER -> FIXUP -> IDLE
  always_comb begin
    state_s    = state_r;
    op_s       = op_r;
    xs_s       = xs_r;
    ys_s       = ys_r;
    dbz_pend_s = dbz_pend_r;
    opnd_s     = opnd_r;
    work_hi_s  = work_hi_r;
    work_lo_s  = work_lo_r;
    cnt_s      = cnt_r;
    prodh_s    = prodh_r;
    prodl_s    = prodl_r;
    run_s      = run_r;
    done_s     = 1'b0;
    dbz_s      = dbz_r;
    dbz_prev_s = dbz_prev_r;
    case (state_r)
      ST_IDLE: begin
        // cancel wins over a same-cycle start
        if (start && !cancel) begin
          op_s       = op;
          xs_s       = x_neg_s;
          ys_s       = y_neg_s;
          work_lo_s  = x_neg_s ? -x : x;
          opnd_s     = y_neg_s ? -y : y;
          work_hi_s  = {WIDTH{1'b0}};
          cnt_s      = {CNT_W{1'b0}};
          run_s      = 1'b1;
          dbz_prev_s = dbz_r;
          dbz_s      = 1'b0;
          if ((op == OP_DIV) && (y == {WIDTH{1'b0}})) begin
            dbz_pend_s = 1'b1;
            work_hi_s  = x;
            state_s    = ST_FIXUP;
          end else begin
            dbz_pend_s = 1'b0;
            state_s    = ST_ITER;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ITER: begin
        if (cancel) begin
          state_s = ST_IDLE;
          run_s   = 1'b0;
          dbz_s   = dbz_prev_r;
        end else begin
          work_hi_s = step_hi_s;
          work_lo_s = step_lo_s;
          cnt_s     = cnt_r + CNT_ONE;
          if (cnt_r == LAST_CNT) begin
            state_s = ST_FIXUP;
          end else begin
            state_s = ST_ITER;
          end
        end
      end
      ST_FIXUP: begin
        if (cancel) begin
          state_s = ST_IDLE;
          run_s   = 1'b0;
          dbz_s   = dbz_prev_r;
        end else begin
          prodh_s = result_s[2*WIDTH-1:WIDTH];
          prodl_s = result_s[WIDTH-1:0];
          done_s  = 1'b1;
          run_s   = 1'b0;
          dbz_s   = dbz_pend_r;
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        run_s   = 1'b0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Working registers and registered outputs
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      op_r       <= 2'b00;
      xs_r       <= 1'b0;
      ys_r       <= 1'b0;
      dbz_pend_r <= 1'b0;
      opnd_r     <= {WIDTH{1'b0}};
      work_hi_r  <= {WIDTH{1'b0}};
      work_lo_r  <= {WIDTH{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      prodh_r    <= {WIDTH{1'b0}};
      prodl_r    <= {WIDTH{1'b0}};
      run_r      <= 1'b0;
      done_r     <= 1'b0;
      dbz_r      <= 1'b0;
      dbz_prev_r <= 1'b0;
    end else begin
      op_r       <= op_s;
      xs_r       <= xs_s;
      ys_r       <= ys_s;
      dbz_pend_r <= dbz_pend_s;
      opnd_r     <= opnd_s;
      work_hi_r  <= work_hi_s;
      work_lo_r  <= work_lo_s;
      cnt_r      <= cnt_s;
      prodh_r    <= prodh_s;
      prodl_r    <= prodl_s;
      run_r      <= run_s;
      done_r     <= done_s;
      dbz_r      <= dbz_s;
      dbz_prev_r <= dbz_prev_s;
    end
  end

  assign prodh        = prodh_r;
  assign prodl        = prodl_r;
  assign run          = run_r;
  assign done         = done_r;
  assign dividebyzero = dbz_r;

endmodule

// File: tb/tb_multdiv_param.sv
// Self-checking bench for multdiv_param: directed vector table, control corner sequences,
// and corner-value sweeps at W=32/B=1 and W=8/B=1,2,4 against an arithmetic reference model.
`timescale 1ns/1ps
module tb_multdiv_param;

  logic        clk = 1'b0;
  logic        reset_b, start, start8, signedop, cancel;
  logic [1:0]  op;
  logic [31:0] x, y, prodh, prodl;
  logic        run, done, dividebyzero;
  logic [7:0]  x8, y8;
  logic [7:0]  ph8 [3];
  logic [7:0]  pl8 [3];
  logic        run8 [3];
  logic        done8 [3];
  logic        dbz8 [3];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] res;
    logic        dbz;
    int          lat;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        dbz;
    int          lat;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        tbl[$];
  logic [63:0] acc_m;
  logic [63:0] acc8_m;

  always #5 clk = ~clk;

  multdiv_param #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut (
    .clk(clk), .reset_b(reset_b), .start(start), .op(op), .signedop(signedop), .cancel(cancel),
    .x(x), .y(y), .prodh(prodh), .prodl(prodl), .run(run), .done(done), .dividebyzero(dividebyzero));

  multdiv_param #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_w8b1 (
    .clk(clk), .reset_b(reset_b), .start(start8), .op(op), .signedop(signedop), .cancel(cancel),
    .x(x8), .y(y8), .prodh(ph8[0]), .prodl(pl8[0]), .run(run8[0]), .done(done8[0]), .dividebyzero(dbz8[0]));

  multdiv_param #(.WIDTH(8), .BITS_PER_CYCLE(2)) u_w8b2 (
    .clk(clk), .reset_b(reset_b), .start(start8), .op(op), .signedop(signedop), .cancel(cancel),
    .x(x8), .y(y8), .prodh(ph8[1]), .prodl(pl8[1]), .run(run8[1]), .done(done8[1]), .dividebyzero(dbz8[1]));

  multdiv_param #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_w8b4 (
    .clk(clk), .reset_b(reset_b), .start(start8), .op(op), .signedop(signedop), .cancel(cancel),
    .x(x8), .y(y8), .prodh(ph8[2]), .prodl(pl8[2]), .run(run8[2]), .done(done8[2]), .dividebyzero(dbz8[2]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit operands, result packed as {HI,LO} in 2w bits.
  function automatic logic [63:0] model(input int w, input logic [1:0] o, input logic s,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] acc, output logic dz);
    logic [63:0] m1, m2, ua, ub, r, qu, ru;
    longint sa, sb, p, q, rm;
    m1 = (64'd1 << w) - 64'd1;
    m2 = (w >= 32) ? {64{1'b1}} : ((64'd1 << (2 * w)) - 64'd1);
    ua = {32'd0, a} & m1;
    ub = {32'd0, b} & m1;
    sa = (s && ua[w-1]) ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb = (s && ub[w-1]) ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    p  = sa * sb;
    dz = 1'b0;
    r  = 64'd0;
    case (o)
      2'b00: r = p;
      2'b10: r = acc + p;
      2'b11: r = acc - p;
      default: begin
        if (ub == 64'd0) begin
          dz = 1'b1;
          r  = (ua << w) | m1;
        end else begin
          q  = sa / sb;
          rm = sa % sb;
          qu = q;
          ru = rm;
          r  = ((ru & m1) << w) | (qu & m1);
        end
      end
    endcase
    return r & m2;
  endfunction

  // Drive one W=32 operation from a negedge; returns at the negedge where done is seen.
  task automatic run_op(input string name, input logic [1:0] o, input logic s,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] er, input logic ed, input int el);
    exp_t e;
    int   cyc;
    e.res = er; e.dbz = ed; e.lat = el;
    sb_q.push_back(e);
    op = o; signedop = s; x = a; y = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({name, " run"}, {63'd0, run}, 64'd1);
    chk({name, " dbz cleared"}, {63'd0, dividebyzero}, 64'd0);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      chk({name, " timeout"}, {63'd0, done}, 64'd1);
      void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      chk({name, " result"}, {prodh, prodl}, e.res);
      chk({name, " dbz"}, {63'd0, dividebyzero}, {63'd0, e.dbz});
      chk({name, " latency"}, 64'(cyc), 64'(e.lat));
    end
  endtask

  // Drive one op into the three W=8 units and check each at its own latency.
  task automatic run_op8(input string name, input logic [1:0] o, input logic s,
                         input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   cyc;
    logic dz;
    logic seen [3];
    int   nb [3];
    nb = '{8, 4, 2};
    e.res = model(8, o, s, a, b, acc8_m, dz);
    e.dbz = dz;
    e.lat = 0;
    sb_q.push_back(e);
    acc8_m = e.res;
    op = o; signedop = s; x8 = a[7:0]; y8 = b[7:0]; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    seen = '{1'b0, 1'b0, 1'b0};
    cyc = 0;
    while (!(seen[0] && seen[1] && seen[2]) && cyc < 30) begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 3; k++) begin
        if (!seen[k] && done8[k]) begin
          seen[k] = 1'b1;
          chk($sformatf("%s b%0d result", name, k), {48'd0, ph8[k], pl8[k]}, e.res);
          chk($sformatf("%s b%0d dbz", name, k), {63'd0, dbz8[k]}, {63'd0, e.dbz});
          chk($sformatf("%s b%0d latency", name, k), 64'(cyc), 64'(dz ? 1 : nb[k] + 1));
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (!seen[k]) chk($sformatf("%s b%0d timeout", name, k), 64'd0, 64'd1);
    end
    void'(sb_q.pop_front());
  endtask

  task automatic add_vec(input logic [1:0] o, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] r, input logic d, input int l);
    vec_t v;
    v.op = o; v.sg = s; v.a = a; v.b = b; v.res = r; v.dbz = d; v.lat = l;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] cn [8];
    logic [63:0] er;
    logic        ed;
    logic        seen;
    int          cyc;
    logic [1:0]  o;

    cn = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0002, 32'h7FFF_FFFF,
           32'h8000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hABCD_EF01};
    reset_b = 1'b1; start = 1'b0; start8 = 1'b0; cancel = 1'b0; signedop = 1'b0;
    op = 2'b00; x = 32'd0; y = 32'd0; x8 = 8'd0; y8 = 8'd0;
    acc_m = 64'd0; acc8_m = 64'd0;

    // Directed vectors with hand-derived results
    add_vec(2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 33);
    add_vec(2'b01, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 33);
    add_vec(2'b01, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 64'h0000_0001_7FFF_FFFC, 1'b0, 33);
    add_vec(2'b01, 1'b0, 32'h2345_6789, 32'h0000_0000, 64'h2345_6789_FFFF_FFFF, 1'b1, 1);
    add_vec(2'b00, 1'b0, 32'h0000_0005, 32'h0000_0001, 64'h0000_0000_0000_0005, 1'b0, 33);
    add_vec(2'b10, 1'b1, 32'hFFFF_FFFF, 32'h0000_0003, 64'h0000_0000_0000_0002, 1'b0, 33);
    add_vec(2'b11, 1'b1, 32'h0000_0002, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 33);
    add_vec(2'b01, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 33);
    add_vec(2'b00, 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 33);
    add_vec(2'b00, 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 33);

    #1 reset_b = 1'b0;
    #2;
    chk("reset hilo", {prodh, prodl}, 64'd0);
    chk("reset ctl", {61'd0, run, done, dividebyzero}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);

    // Table pass, issued back-to-back
    for (int i = 0; i < tbl.size(); i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].sg, tbl[i].a, tbl[i].b,
             tbl[i].res, tbl[i].dbz, tbl[i].lat);
    end
    @(negedge clk);
    chk("done one cycle", {63'd0, done}, 64'd0);
    chk("run idle", {63'd0, run}, 64'd0);

    // Cancel on the 10th ITER cycle restores the pre-start dividebyzero and keeps HI/LO
    run_op("dbz pre", 2'b01, 1'b0, 32'h0000_0011, 32'h0, 64'h0000_0011_FFFF_FFFF, 1'b1, 1);
    op = 2'b00; signedop = 1'b0; x = 32'd7; y = 32'd9; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("cancel dbz cleared", {63'd0, dividebyzero}, 64'd0);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel run", {63'd0, run}, 64'd0);
    chk("cancel done", {63'd0, done}, 64'd0);
    chk("cancel dbz restored", {63'd0, dividebyzero}, 64'd1);
    chk("cancel hilo kept", {prodh, prodl}, 64'h0000_0011_FFFF_FFFF);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("cancel no done", {63'd0, seen}, 64'd0);

    // start raised while running is ignored
    op = 2'b00; signedop = 1'b0; x = 32'd3; y = 32'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      start = (cyc >= 5 && cyc < 8);
      if (start) begin
        op = 2'b01; x = 32'd100; y = 32'd100;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("ignore start latency", 64'(cyc), 64'd33);
    chk("ignore start result", {prodh, prodl}, 64'd15);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("ignore start no extra done", {63'd0, seen}, 64'd0);

    // Asynchronous reset in the middle of a divide
    op = 2'b01; signedop = 1'b0; x = 32'd1000; y = 32'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset_b = 1'b0;
    #1;
    chk("async reset hilo", {prodh, prodl}, 64'd0);
    chk("async reset ctl", {61'd0, run, done, dividebyzero}, 64'd0);
    @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    acc_m = 64'd0;

    // W=32 corner sweep, back-to-back, against the model
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 8; j++) begin
          o  = 2'((i + j + s) % 4);
          er = model(32, o, s[0], cn[i], cn[j], acc_m, ed);
          run_op($sformatf("w32 op%0d s%0d %h %h", o, s, cn[i], cn[j]),
                 o, s[0], cn[i], cn[j], er, ed, ed ? 1 : 33);
          acc_m = er;
        end
      end
    end

    // W=8 sweep across BITS_PER_CYCLE 1, 2, 4
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 8; j++) begin
          o = 2'((i + 2 * j + s) % 4);
          run_op8($sformatf("w8 op%0d s%0d %h %h", o, s, cn[i][7:0], cn[j][7:0]),
                  o, s[0], cn[i], cn[j]);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
